// File: rtl/bitop_pipe_pkg.sv
// rtl/bitop_pipe_pkg.sv - shared mode encoding for the bitop pipeline
package bitop_pipe_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_XNOR = 2'd3
  } mode_e;

endpackage

// File: rtl/bitop_stage.sv
// rtl/bitop_stage.sv - one valid/ready register slice of the bitop pipeline
module bitop_stage #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  input  logic             i_ready,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  // Slot may load when empty or when its word leaves this same edge.
  assign o_ready = ~o_valid | i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q     <= '0;
      o_valid <= 1'b0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_q <= i_d;
      end
    end
  end

endmodule

// File: rtl/bitop_pipe.sv
// rtl/bitop_pipe.sv - pipelined per-word pass/invert/xor/xnor with output counter
module bitop_pipe
  import bitop_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_mask,
  input  logic               i_mask_we,
  output logic [WIDTH-1:0]   o_y,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COUNT_W-1:0] o_count
);

  logic [WIDTH-1:0]              mask;
  logic [WIDTH-1:0]              op_y;
  logic [STAGES:0][WIDTH-1:0]    sd;
  logic [STAGES:0]               sv;
  logic [STAGES:0]               sr;

  // Uses the mask value before any write landing on the acceptance edge.
  always_comb begin
    op_y = i_x;
    case (i_mode)
      MODE_PASS: op_y = i_x;
      MODE_INV:  op_y = ~i_x;
      MODE_XOR:  op_y = i_x ^ mask;
      MODE_XNOR: op_y = ~(i_x ^ mask);
      default:   op_y = i_x;
    endcase
  end

  assign sd[0]      = op_y;
  assign sv[0]      = i_valid;
  assign sr[STAGES] = i_ready;
  assign o_ready    = sr[0];
  assign o_y        = sd[STAGES];
  assign o_valid    = sv[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bitop_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (sd[g]),
      .i_valid (sv[g]),
      .i_ready (sr[g+1]),
      .o_ready (sr[g]),
      .o_q     (sd[g+1]),
      .o_valid (sv[g+1])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask <= '0;
    end else if (i_mask_we) begin
      mask <= i_mask;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (o_valid && i_ready) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bitop_pipe.sv
// tb/tb_bitop_pipe.sv - self-checking bench for bitop_pipe
module tb_bitop_pipe;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [W-1:0]  i_x;
  logic [1:0]    i_mode;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_mask;
  logic          i_mask_we;
  logic [W-1:0]  o_y;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_count;

  bitop_pipe #(.WIDTH(W), .STAGES(S), .COUNT_W(CW)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_x       (i_x),
    .i_mode    (i_mode),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_mask    (i_mask),
    .i_mask_we (i_mask_we),
    .o_y       (o_y),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_count   (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int            nvec = 0;
  int            nmiss = 0;
  logic [W-1:0]  expq[$];
  logic [W-1:0]  mask_m;
  logic [CW-1:0] cnt_m;
  int            out_cnt = 0;
  logic          held;
  logic [W-1:0]  held_y;

  // bit 1 of the mode selects masking, bit 0 selects a final inversion
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [1:0] m,
                                          input logic [W-1:0] k);
    logic [W-1:0] r;
    r = x;
    if (m[1]) r = r ^ k;
    if (m[0]) r = ~r;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("ready", {31'd0, o_ready}, {31'd0, (expq.size() < S) || i_ready});
      chk("count", {28'd0, o_count}, {28'd0, cnt_m});
      if (held) chk("hold", {23'd0, o_valid, o_y}, {23'd0, 1'b1, held_y});
      held   = o_valid && !i_ready;
      held_y = o_y;
      if (o_valid && i_ready) begin
        if (expq.size() == 0) chk("out_underflow", expq.size(), 1);
        else chk("data", {24'd0, o_y}, {24'd0, expq.pop_front()});
        cnt_m = cnt_m + 1'b1;
        out_cnt++;
      end
      if (i_valid && o_ready) expq.push_back(ref_op(i_x, i_mode, mask_m));
      if (i_mask_we) mask_m = i_mask;
    end
  end

  task automatic clear_model();
    expq.delete();
    cnt_m  = '0;
    mask_m = '0;
    held   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_count", {28'd0, o_count}, 0);
    clear_model();
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  // kind: 0 free-running sink, 1 sink stalled in cycles 3-6, 2 random, 3 sink stalled
  task automatic run_stream(input int n, input int kind, input int max_cycles, output bit saw_block);
    int idx;
    int c;
    idx = 0;
    c = 0;
    saw_block = 1'b0;
    while (idx < n && c < max_cycles) begin
      @(posedge i_clk);
      #1;
      i_valid   = (kind == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_x       = W'($urandom);
      i_mode    = 2'($urandom_range(0, 3));
      i_mask    = W'($urandom);
      i_mask_we = (kind == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      case (kind)
        1:       i_ready = !(c >= 3 && c <= 6);
        2:       i_ready = ($urandom_range(0, 2) != 0);
        3:       i_ready = 1'b0;
        default: i_ready = 1'b1;
      endcase
      @(negedge i_clk);
      if (i_valid && o_ready) idx++;
      if (!o_ready) saw_block = 1'b1;
      c++;
    end
    chk("stream_budget", idx, n);
  endtask

  task automatic drain();
    @(posedge i_clk);
    #1;
    i_valid   = 1'b0;
    i_mask_we = 1'b0;
    i_ready   = 1'b1;
    for (int k = 0; k < 20 && expq.size() != 0; k++) @(posedge i_clk);
    #1;
    chk("drain", expq.size(), 0);
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [1:0]   mode;
    logic         we;
    logic [W-1:0] mask;
    logic [W-1:0] y;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit blk;
    int lat;
    int out0;

    tbl[0] = '{8'hA5, 2'd1, 1'b0, 8'h00, 8'h5A};
    tbl[1] = '{8'h5A, 2'd2, 1'b0, 8'h00, 8'h5A};
    tbl[2] = '{8'h00, 2'd0, 1'b1, 8'h0F, 8'h00};
    tbl[3] = '{8'h3C, 2'd2, 1'b0, 8'h00, 8'h33};
    tbl[4] = '{8'h3C, 2'd3, 1'b0, 8'h00, 8'hCC};
    tbl[5] = '{8'h01, 2'd2, 1'b1, 8'hFF, 8'h0E};
    tbl[6] = '{8'h01, 2'd2, 1'b0, 8'h00, 8'hFE};
    tbl[7] = '{8'hC3, 2'd3, 1'b0, 8'h00, 8'hC3};
    tbl[8] = '{8'h96, 2'd0, 1'b0, 8'h00, 8'h96};

    i_rst_n = 1'b0;
    i_x = '0;
    i_mode = '0;
    i_valid = 1'b0;
    i_mask = '0;
    i_mask_we = 1'b0;
    i_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    #1;
    chk("reset_valid", {31'd0, o_valid}, 0);
    chk("reset_y", {24'd0, o_y}, 0);
    chk("reset_count", {28'd0, o_count}, 0);
    chk("reset_ready", {31'd0, o_ready}, 1);

    for (int i = 0; i < 9; i++) begin
      @(posedge i_clk);
      #1;
      i_x = tbl[i].x;
      i_mode = tbl[i].mode;
      i_mask = tbl[i].mask;
      i_mask_we = tbl[i].we;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("tbl_accept", {31'd0, o_ready}, 1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_mask_we = 1'b0;
      lat = 0;
      while (!o_valid && lat < 10) begin
        @(posedge i_clk);
        #1;
        lat++;
      end
      chk("tbl_latency", lat, S - 1);
      chk("tbl_y", {24'd0, o_y}, {24'd0, tbl[i].y});
      @(posedge i_clk);
      #1;
      if (i == 0) chk("first_count", {28'd0, o_count}, 1);
    end

    out0 = out_cnt;
    run_stream(8, 1, 100, blk);
    chk("stall_ready_low", {31'd0, blk}, 1);
    drain();
    chk("stall_words_out", out_cnt - out0, 8);

    run_stream(300, 2, 3000, blk);
    drain();

    do_reset();
    run_stream(17, 0, 100, blk);
    drain();
    chk("wrap_count", {28'd0, o_count}, 1);

    run_stream(2, 3, 100, blk);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("pre_rst_valid", {31'd0, o_valid}, 1);
    chk("pre_rst_count", {28'd0, o_count}, 1);
    do_reset();
    out0 = out_cnt;
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    chk("no_replay", out_cnt - out0, 0);
    chk("post_rst_valid", {31'd0, o_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/bitop_pipe.md
Name: bitop_pipe

Overview:
- Parametrised, pipelined successor to the combinational N-bit inverter.
- Applies a per-word selectable bitwise operation (pass, invert, XOR-mask, XNOR-mask) to a WIDTH-bit stream.
- Fixed latency of STAGES cycles, with valid/ready backpressure on both sides.
- Sits between a stream source (UART RX, switch sampler) and a sink (LED/7-seg driver, UART TX) in the lab examples; also keeps a wrapping count of output words.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- STAGES, 2, number of pipeline register stages (>=1); equals latency in cycles.
- COUNT_W, 16, width of the output-word counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_x  in  WIDTH  input data word.
- i_mode  in  2  operation for this word: 0 pass, 1 invert, 2 XOR mask, 3 XNOR mask.
- i_valid  in  1  input word valid.
- o_ready  out  1  block can accept the input word this cycle.
- i_mask  in  WIDTH  new mask value.
- i_mask_we  in  1  load i_mask into mask register.
- o_y  out  WIDTH  result word.
- o_valid  out  1  o_y valid.
- i_ready  in  1  sink accepts o_y.
- o_count  out  COUNT_W  number of completed output handshakes, modulo 2^COUNT_W.

Behaviour:
- Reset values:
  - All stage valid bits 0, so o_valid=0.
  - o_y=0, mask register=0, o_count=0.
  - o_ready=1 once reset is released.
- Reset asserted mid-stream: in-flight words are discarded immediately (asynchronous); nothing is replayed.
- Handshakes:
  - Input handshake: i_valid & o_ready. Output handshake: o_valid & i_ready.
  - o_valid, once high, stays high with o_y stable until the output handshake completes.
  - o_ready does not depend combinationally on i_valid.
- Pipeline:
  - Stage k holds {data, valid}. Stage k may load when its slot is empty or is draining: ready_k = ~valid_k | ready_(k+1). The last stage's downstream ready is i_ready; o_ready = ready_0.
  - With no backpressure, a word accepted at edge n appears on o_y/o_valid after edge n+STAGES-1, i.e. visible in cycle n+STAGES.
  - Sustained throughput is 1 word/cycle.
  - Bubbles are not required to be squeezed out unless downstream is stalled.
- Operation:
  - Computed combinationally on the input word at acceptance, from i_mode and the mask register value, and captured into stage 0.
  - Later stages only delay the word; no output flops beyond the last stage.
  - Results: mode0 y=x; mode1 y=~x; mode2 y=x^mask; mode3 y=~(x^mask).
- Mask register:
  - Updated on the edge where i_mask_we=1.
  - A word accepted on that same edge uses the old mask.
  - Mask writes never disturb words already in flight.
- Counter:
  - o_count increments by 1 on each output handshake.
  - Wraps from 2^COUNT_W-1 to 0.
  - Not affected by input handshakes.
- Simultaneous events:
  - Input and output handshakes in the same cycle with a full pipeline is legal: every stage shifts, throughput stays 1/cycle.
  - i_mask_we together with an input handshake follows the mask-register rule above.
- Stall: with i_ready=0 and all stages valid, o_ready=0; stage contents and o_y are held.

Decomposition:
- Shared package holds:
  - mode encoding constants MODE_PASS=0, MODE_INV=1, MODE_XOR=2, MODE_XNOR=3;
  - the mode field width (2).
- One sub-module is natural: bitop_stage, a single WIDTH-bit valid/ready register slice (data+valid flop, ready_k logic).
  - Instantiated STAGES times in a generate loop.
- The operation mux and the counter stay in the top.

Test Plan (WIDTH=8, STAGES=2, COUNT_W=4):
- Reset, then i_x=8'hA5, mode1, i_valid for 1 cycle, i_ready=1 -> o_valid high exactly 2 cycles after acceptance with o_y=8'h5A; o_count=1.
- Mask write 8'h0F, then x=8'h3C mode2, then x=8'h3C mode3 -> o_y=8'h33 then 8'hCC.
- i_mask_we=1 (mask 8'hFF) on the same edge as accepting x=8'h01 mode2 with old mask 8'h0F -> o_y=8'h0E. Next word x=8'h01 mode2 -> o_y=8'hFE.
- Stream 8 words back-to-back, i_ready=0 for cycles 3-6 -> o_ready drops once both stages fill; no word lost or duplicated; output order equals input order; o_y held stable while stalled.
- 17 words streamed with i_ready=1 -> o_count wraps to 1.
- i_rst_n pulsed low with 2 words in flight -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge; those words never appear after reset is released.
